// File: rtl/gray_ptr_counter.sv
// ---------------------------------------------------------------------------
// gray_ptr_counter
//   One side of an asynchronous FIFO pointer pair. Keeps a registered binary
//   and Gray pointer, and compares against the opposite-domain Gray pointer.
//   The caller synchronises that pointer. The block then produces registered
//   full/empty, almost and occupancy flags.
//
// Parameters
//   ADDR_WIDTH     FIFO address width (2..16); pointer width PW = ADDR_WIDTH+1
//   SIDE           0 = write pointer (status = full), 1 = read pointer (empty)
//   ALMOST_MARGIN  almost threshold (0..D-1), D = 2**ADDR_WIDTH
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   clr          synchronous clear, same effect as rst
//   inc_en       request to advance the pointer by one
//   remote_gray  opposite-domain Gray pointer (already synchronised)
//   ptr_bin      registered binary pointer
//   ptr_gray     registered Gray pointer, exported to the other domain
//   addr         RAM address (low ADDR_WIDTH bits of ptr_bin)
//   level        registered occupancy, 0..D
//   status       registered full (SIDE=0) / empty (SIDE=1)
//   almost       registered almost_full (SIDE=0) / almost_empty (SIDE=1)
//   ovf          one-cycle pulse: request arrived while status was set
//   wrap         one-cycle pulse: ptr_bin rolled over from all-ones to zero
// ---------------------------------------------------------------------------
module gray_ptr_counter #(
    parameter int ADDR_WIDTH    = 4,
    parameter int SIDE          = 0,
    parameter int ALMOST_MARGIN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc_en,
    input  logic [ADDR_WIDTH:0]   remote_gray,
    output logic [ADDR_WIDTH:0]   ptr_bin,
    output logic [ADDR_WIDTH:0]   ptr_gray,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  status,
    output logic                  almost,
    output logic                  ovf,
    output logic                  wrap
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int D  = 1 << ADDR_WIDTH;

    localparam logic [PW-1:0] AF_THRESH = PW'(D - ALMOST_MARGIN);
    localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_MARGIN);

    // A read pointer comes out of reset empty (and therefore almost empty).
    // A write pointer comes out of reset neither full nor almost full.
    localparam logic RST_FLAG = (SIDE != 0);

    logic          inc_ok;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] remote_bin;
    logic [PW-1:0] diff;
    logic          status_next;
    logic          almost_next;

    // Pointer advance. A blocked request never moves the pointer.
    always_comb begin
        inc_ok    = inc_en & ~status;
        bin_next  = ptr_bin + PW'(inc_ok);
        gray_next = bin_next ^ (bin_next >> 1);
    end

    // Gray-to-binary conversion: a prefix XOR from the MSB down.
    always_comb begin
        remote_bin = '0;
        remote_bin[PW-1] = remote_gray[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            remote_bin[i] = remote_bin[i+1] ^ remote_gray[i];
        end
    end

    // Flag logic looks at the next local pointer. This lets the flags and the
    // pointer update on the same edge. Both sources feed one computation, so
    // a local increment and a remote change in the same cycle are both used.
    generate
        if (SIDE == 0) begin : g_wr
            // Full: pointers equal except for the wrap bit. In Gray code,
            // that means the top two bits are inverted.
            always_comb begin
                diff        = bin_next - remote_bin;
                status_next = (gray_next == {~remote_gray[PW-1:PW-2], remote_gray[PW-3:0]});
                almost_next = (diff >= AF_THRESH);
            end
        end else begin : g_rd
            always_comb begin
                diff        = remote_bin - bin_next;
                status_next = (gray_next == remote_gray);
                almost_next = (diff <= AE_THRESH);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr_bin  <= '0;
            ptr_gray <= '0;
            level    <= '0;
            status   <= RST_FLAG;
            almost   <= RST_FLAG;
            ovf      <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            ptr_bin  <= bin_next;
            ptr_gray <= gray_next;
            level    <= diff;
            status   <= status_next;
            almost   <= almost_next;
            ovf      <= inc_en & status;
            wrap     <= inc_ok & (&ptr_bin);
        end
    end

    assign addr = ptr_bin[ADDR_WIDTH-1:0];

endmodule

// File: doc/gray_ptr_counter.md
GRAY_PTR_COUNTER -- requirements
Module: gray_ptr_counter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: FIFO address width; legal range 2..16; pointer width PW = ADDR_WIDTH+1, depth D = 2^ADDR_WIDTH.
REQ-002 Parameter SIDE, default 0: 0 = write-side pointer (status = full); 1 = read-side pointer (status = empty).
REQ-003 Parameter ALMOST_MARGIN, default 1: threshold for almost flag; legal range 0..D-1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset: synchronous, active-high.
REQ-006 clr  input  1  synchronous clear, same effect as rst, lower priority.
REQ-007 inc_en  input  1  request to advance pointer by one.
REQ-008 remote_gray  input  PW  opposite-domain Gray pointer, already synchronised by caller.
REQ-009 ptr_bin  output  PW  registered binary pointer.
REQ-010 ptr_gray  output  PW  registered Gray pointer, for export to the other domain.
REQ-011 addr  output  ADDR_WIDTH  ptr_bin[ADDR_WIDTH-1:0], RAM address.
REQ-012 level  output  PW  registered occupancy, 0..D.
REQ-013 status  output  1  registered full (SIDE=0) or empty (SIDE=1).
REQ-014 almost  output  1  registered almost_full (SIDE=0) or almost_empty (SIDE=1).
REQ-015 ovf  output  1  one-cycle pulse: inc_en asserted while status=1 (overflow/underflow attempt).
REQ-016 wrap  output  1  one-cycle pulse, registered: ptr_bin advanced from 2^PW-1 to 0.

Function
REQ-017 Accepted increment inc_ok = inc_en AND NOT status; blocked requests never move the pointer.
REQ-018 bin_next = ptr_bin + inc_ok, modulo 2^PW; ptr_bin <= bin_next every cycle.
REQ-019 gray_next = bin_next XOR (bin_next >> 1); ptr_gray <= gray_next; ptr_gray is always a registered value, never combinational, and changes at most one bit per cycle.
REQ-020 remote_bin = Gray-to-binary of remote_gray: bit PW-1 passes through, bit i = remote_bin[i+1] XOR remote_gray[i]; combinational, internal only.
REQ-021 SIDE=0: status <= (gray_next == {~remote_gray[PW-1:PW-2], remote_gray[PW-3:0]}).
REQ-022 SIDE=1: status <= (gray_next == remote_gray).
REQ-023 SIDE=0: level <= bin_next - remote_bin; SIDE=1: level <= remote_bin - bin_next; both modulo 2^PW.
REQ-024 SIDE=0: almost <= (bin_next - remote_bin) >= D - ALMOST_MARGIN; SIDE=1: almost <= (remote_bin - bin_next) <= ALMOST_MARGIN.
REQ-025 Latency: status, level, almost reflect an accepted increment or a remote_gray change in the cycle immediately after it (one register stage).
REQ-026 ovf <= inc_en AND status; wrap <= inc_ok AND (ptr_bin == 2^PW-1).
REQ-027 Simultaneous local increment and remote_gray change: both are used in the same next-state computation; no event is dropped.
REQ-028 Pointer wrap-around is seamless: Gray step 2^PW-1 -> 0 is single-bit; level stays correct across wrap.

Reset
REQ-029 On rst or clr: ptr_bin=0, ptr_gray=0, level=0, ovf=0, wrap=0; status=0 for SIDE=0, 1 for SIDE=1; almost=(ALMOST_MARGIN==0 ? 0 : 0) for SIDE=0, 1 for SIDE=1.
REQ-030 rst and clr override inc_en in the same cycle; no ovf or wrap pulse results.
REQ-031 Caller shall clear both sides together; the block does not coordinate clr across domains.

Verification (ADDR_WIDTH=3, PW=4, D=8, ALMOST_MARGIN=1)
REQ-032 rst high 2 cycles -> ptr_bin=0, ptr_gray=0, level=0; SIDE=0: status=0, almost=0; SIDE=1: status=1, almost=1.
REQ-033 SIDE=0, remote_gray=0, inc_en held 9 cycles -> ptr_bin 1..8, level 7 gives almost=1, at ptr_bin=8 ptr_gray=4'hC, status=1, level=8; 9th request: ptr_bin stays 8, ovf pulses once.
REQ-034 Free-run 16 increments with remote kept non-blocking -> ptr_gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; one bit changes per step; wrap pulses exactly once, on 15->0.
REQ-035 SIDE=1, remote_gray=4'h3 (bin 2) -> next cycle level=2, status=0, almost=0; two increments -> level=0, status=1; third request blocked, ovf=1.
REQ-036 Simultaneous: SIDE=0, level=8, status=1, remote_gray steps to bin 1 while inc_en=1 -> increment blocked that cycle (ovf=1), next cycle status=0, level=7; following inc accepted, level=8.
REQ-037 rst asserted at ptr_bin=5 with inc_en=1 -> next cycle ptr_bin=0, ptr_gray=0, ovf=0, wrap=0.
